// File: rtl/subtractor_seq.sv
// rtl/subtractor_seq.sv - multi-cycle digit-serial subtractor with valid/ready handshakes
//
// Computes diff = in0 - in1 - bin, one DIGIT_WIDTH-bit digit per cycle, with a
// registered borrow chain. Optional macro: SUBTRACTOR_SAT_EN (unsigned saturation
// to zero when the final borrow is set).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   in0        minuend, WIDTH bits
//   in1        subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   diff       difference modulo 2^WIDTH, WIDTH bits
//   bout       borrow-out, 1 iff in0 < in1 + bin

module subtractor_seq #(
   parameter int WIDTH       = 32,
   parameter int DIGIT_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int NDIG = WIDTH / DIGIT_WIDTH;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

   generate
      if (WIDTH % DIGIT_WIDTH != 0) begin : g_width_check
         $error("subtractor_seq: WIDTH must be a multiple of DIGIT_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;
   logic                   borrow_q;
   logic [CW-1:0]          k_q;
   logic [DIGIT_WIDTH-1:0] a_dig;
   logic [DIGIT_WIDTH-1:0] b_dig;
   logic [DIGIT_WIDTH:0]   digit_sub;
   logic                   last_digit;

   // Select the current digit of each operand. A compare per digit keeps every
   // part-select index constant.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (k_q == CW'(d)) begin
            a_dig = a_q[d*DIGIT_WIDTH +: DIGIT_WIDTH];
            b_dig = b_q[d*DIGIT_WIDTH +: DIGIT_WIDTH];
         end
      end
   end

   // Zero-extended subtract: the MSB of the (DIGIT_WIDTH+1)-bit result is the
   // borrow into the next digit.
   assign digit_sub  = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT_WIDTH+1)'(borrow_q);
   assign last_digit = (k_q == LAST_DIGIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Leaving DONE waits for the registered out_valid so that the
            // consumer always sees at least one valid cycle.
            if (out_valid && out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         borrow_q  <= 1'b0;
         k_q       <= '0;
         diff      <= '0;
         bout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_valid) begin
                  a_q      <= in0;
                  b_q      <= in1;
                  borrow_q <= bin;
                  k_q      <= '0;
               end
            end
            RUN: begin
               for (int d = 0; d < NDIG; d++) begin
                  if (k_q == CW'(d)) begin
                     diff[d*DIGIT_WIDTH +: DIGIT_WIDTH] <= digit_sub[DIGIT_WIDTH-1:0];
                  end
               end
               borrow_q <= digit_sub[DIGIT_WIDTH];
               k_q      <= k_q + 1'b1;
               if (last_digit) begin
                  bout <= digit_sub[DIGIT_WIDTH];
`ifdef SUBTRACTOR_SAT_EN
                  // Later assignment overrides the digit write above.
                  if (digit_sub[DIGIT_WIDTH]) begin
                     diff <= '0;
                  end
`endif
               end
            end
            DONE: begin
               // Rises one cycle after entering DONE, falls on the handshake.
               out_valid <= !(out_valid && out_ready);
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
